// File: rtl/pci_pkg.sv
// Shared definitions for the PCI initiator: command codes, FSM states and
// completion status codes.
package pci_pkg;

    localparam logic [3:0] CMD_MEM_READ  = 4'h6;
    localparam logic [3:0] CMD_MEM_WRITE = 4'h7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_LAST,
        S_TURN
    } state_t;

    typedef enum logic [1:0] {
        ST_OK     = 2'd0,
        ST_MABORT = 2'd1,
        ST_RETRY  = 2'd2,
        ST_DISC   = 2'd3
    } status_t;

endpackage

// File: rtl/pci_devsel_timer.sv
// DEVSEL# wait timer: clears on the address phase, counts while enabled and
// flags the final waited clock so the FSM can master-abort on that edge.
module pci_devsel_timer #(
    parameter int DEVSEL_TIMEOUT = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int CW = $clog2(DEVSEL_TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CW'(DEVSEL_TIMEOUT))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = en && (cnt_q == CW'(DEVSEL_TIMEOUT - 1));

endmodule

// File: rtl/pci_initiator.sv
// PCI memory read/write initiator. Optional bus parity outputs (par, par_oe)
// are built when PCI_INITIATOR_PARITY_EN is defined.
module pci_initiator
    import pci_pkg::*;
#(
    parameter int LEN_W          = 4,
    parameter int DEVSEL_TIMEOUT = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [31:0]      req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic [3:0]       req_be,
    input  logic [31:0]      wr_data,
    output logic             wr_ack,
    output logic [31:0]      rd_data,
    output logic             rd_valid,
    output logic             done,
    output logic [1:0]       status,
    output logic             frame_n,
    output logic             irdy_n,
    output logic [3:0]       cbe,
    output logic [31:0]      ad_out,
    output logic             ad_oe,
    input  logic [31:0]      ad_in,
    input  logic             devsel_n,
    input  logic             trdy_n,
    input  logic             stop_n
`ifdef PCI_INITIATOR_PARITY_EN
    ,
    output logic             par,
    output logic             par_oe
`endif
);

    state_t           state_q, state_d;
    status_t          status_q, status_d;
    logic             write_q, write_d;
    logic [31:0]      addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [3:0]       be_q, be_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             any_q, any_d;
    logic             stopped_q, stopped_d;
    logic             abort_q, abort_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    logic in_data, xfer, tstop;
    logic tmr_clr, tmr_en, timeout;

    assign in_data = (state_q == S_DATA) || (state_q == S_LAST);
    assign xfer    = in_data && !abort_q && !devsel_n && !trdy_n;
    assign tstop   = in_data && !abort_q && !devsel_n && !stop_n;
    assign tmr_en  = in_data && !abort_q && devsel_n;

    pci_devsel_timer #(
        .DEVSEL_TIMEOUT(DEVSEL_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .timeout(timeout)
    );

    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        write_d    = write_q;
        addr_d     = addr_q;
        len_d      = len_q;
        be_d       = be_q;
        cnt_d      = cnt_q;
        any_d      = any_q;
        stopped_d  = stopped_q;
        abort_d    = abort_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        req_ready  = 1'b0;
        frame_n    = 1'b1;
        irdy_n     = 1'b1;
        ad_oe      = 1'b0;
        ad_out     = '0;
        cbe        = '0;
        wr_ack     = 1'b0;
        done       = 1'b0;
        tmr_clr    = 1'b0;

        if (xfer) begin
            cnt_d = cnt_q - LEN_W'(1);
            any_d = 1'b1;
            if (write_q) begin
                wr_ack = 1'b1;
            end else begin
                rd_data_d  = ad_in;
                rd_valid_d = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    len_d   = req_len;
                    be_d    = req_be;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                frame_n   = 1'b0;
                ad_oe     = 1'b1;
                ad_out    = addr_q;
                cbe       = write_q ? CMD_MEM_WRITE : CMD_MEM_READ;
                cnt_d     = (len_q == '0) ? LEN_W'(1) : len_q;
                any_d     = 1'b0;
                stopped_d = 1'b0;
                abort_d   = 1'b0;
                tmr_clr   = 1'b1;
                state_d   = (len_q > LEN_W'(1)) ? S_DATA : S_LAST;
            end
            S_DATA: begin
                frame_n = 1'b0;
                irdy_n  = 1'b0;
                cbe     = be_q;
                ad_oe   = write_q;
                ad_out  = write_q ? wr_data : 32'h0;
                if (timeout) begin
                    abort_d = 1'b1;
                    state_d = S_LAST;
                end else if (tstop) begin
                    stopped_d = 1'b1;
                    state_d   = S_LAST;
                end else if (xfer && (cnt_q == LEN_W'(2))) begin
                    state_d = S_LAST;
                end
            end
            S_LAST: begin
                irdy_n = 1'b0;
                cbe    = be_q;
                ad_oe  = write_q;
                ad_out = write_q ? wr_data : 32'h0;
                if (abort_q) begin
                    status_d = ST_MABORT;
                    state_d  = S_TURN;
                end else if (timeout) begin
                    abort_d = 1'b1;
                end else if (xfer || tstop) begin
                    state_d = S_TURN;
                    if (stopped_q || tstop) begin
                        status_d = (any_q || xfer) ? ST_DISC : ST_RETRY;
                    end else begin
                        status_d = ST_OK;
                    end
                end
            end
            S_TURN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            status_q   <= ST_OK;
            write_q    <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            be_q       <= '0;
            cnt_q      <= '0;
            any_q      <= 1'b0;
            stopped_q  <= 1'b0;
            abort_q    <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            be_q       <= be_d;
            cnt_q      <= cnt_d;
            any_q      <= any_d;
            stopped_q  <= stopped_d;
            abort_q    <= abort_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign status   = status_q;

`ifdef PCI_INITIATOR_PARITY_EN
    // PAR trails AD/CBE by one clock, as the bus requires.
    logic par_q, par_d;
    logic par_oe_q, par_oe_d;

    always_comb begin
        par_d    = ^{ad_out, cbe};
        par_oe_d = ad_oe;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_q    <= 1'b0;
            par_oe_q <= 1'b0;
        end else begin
            par_q    <= par_d;
            par_oe_q <= par_oe_d;
        end
    end

    assign par    = par_q;
    assign par_oe = par_oe_q;
`endif

endmodule

// File: tb/tb_pci_initiator.sv
// Scoreboard bench for pci_initiator: directed transactions push expected
// address phases, write beats, read beats and statuses; a monitor pops them.
module tb_pci_initiator;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [3:0]  req_len;
    logic [3:0]  req_be;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic [1:0]  status;
    logic        frame_n;
    logic        irdy_n;
    logic [3:0]  cbe;
    logic [31:0] ad_out;
    logic        ad_oe;
    logic [31:0] ad_in;
    logic        devsel_n;
    logic        trdy_n;
    logic        stop_n;
`ifdef PCI_INITIATOR_PARITY_EN
    logic        par;
    logic        par_oe;
`endif

    pci_initiator #(
        .LEN_W         (4),
        .DEVSEL_TIMEOUT(5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_len  (req_len),
        .req_be   (req_be),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .done     (done),
        .status   (status),
        .frame_n  (frame_n),
        .irdy_n   (irdy_n),
        .cbe      (cbe),
        .ad_out   (ad_out),
        .ad_oe    (ad_oe),
        .ad_in    (ad_in),
        .devsel_n (devsel_n),
        .trdy_n   (trdy_n),
        .stop_n   (stop_n)
`ifdef PCI_INITIATOR_PARITY_EN
        ,
        .par      (par),
        .par_oe   (par_oe)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [35:0] exp_addr[$];
    logic [31:0] exp_wr[$];
    logic [31:0] exp_rd[$];
    logic [1:0]  exp_st[$];
    logic [31:0] wq[$];

    bit          ack_seen = 1'b0;
    logic        frame_prev = 1'b1;
    logic [35:0] ea;
    logic [31:0] ew;
    logic [31:0] er;
    logic [1:0]  es;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexp(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: unexpected output event at %0t", name, $time);
    endtask

    // Monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!frame_n && frame_prev) begin
            if (exp_addr.size() == 0) begin
                unexp("addr_phase");
            end else begin
                ea = exp_addr.pop_front();
                chk("addr_phase", {ad_oe, irdy_n, cbe, ad_out},
                    {1'b1, 1'b1, ea});
            end
        end
        if (wr_ack) begin
            ack_seen = 1'b1;
            if (exp_wr.size() == 0) begin
                unexp("wr_beat");
            end else begin
                ew = exp_wr.pop_front();
                chk("wr_beat", {ad_oe, ad_out}, {1'b1, ew});
            end
        end
        if (rd_valid) begin
            if (exp_rd.size() == 0) begin
                unexp("rd_beat");
            end else begin
                er = exp_rd.pop_front();
                chk("rd_beat", rd_data, er);
            end
        end
        if (done) begin
            if (exp_st.size() == 0) begin
                unexp("done_status");
            end else begin
                es = exp_st.pop_front();
                chk("done_status", status, es);
            end
        end
        frame_prev = frame_n;
    end

    // Local write-data source: advance one word after each acked beat.
    always @(posedge clk) begin
        #1;
        if (ack_seen) begin
            ack_seen = 1'b0;
            if (wq.size() > 0) void'(wq.pop_front());
            wr_data = (wq.size() > 0) ? wq[0] : 32'h0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic tgt(input logic d, input logic t, input logic s);
        devsel_n = d;
        trdy_n   = t;
        stop_n   = s;
    endtask

    task automatic load_wq(input logic [31:0] a, input logic [31:0] b);
        wq.delete();
        wq.push_back(a);
        wq.push_back(b);
        wr_data = a;
    endtask

    // Present a request in IDLE; returns positioned in the ADDR cycle.
    task automatic issue(input logic w, input logic [31:0] a,
                         input logic [3:0] len, input logic [3:0] be);
        chk("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_len   = len;
        req_be    = be;
        exp_addr.push_back({w ? 4'h7 : 4'h6, a});
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        req_be    = '0;
        wr_data   = '0;
        ad_in     = '0;
        tgt(1'b1, 1'b1, 1'b1);
        tick();
        tick();
        #1;
        chk("reset_bus", {frame_n, irdy_n, ad_oe, cbe, ad_out},
            {1'b1, 1'b1, 1'b0, 4'h0, 32'h0});
        chk("reset_local", {done, status, rd_valid, wr_ack, rd_data},
            {1'b0, 2'd0, 1'b0, 1'b0, 32'h0});
        rst_n = 1'b1;
        tick();

        // Single write, len 1
        load_wq(32'hDEADBEEF, 32'h0);
        exp_wr.push_back(32'hDEADBEEF);
        exp_st.push_back(2'd0);
        issue(1'b1, 32'h0000_1000, 4'd1, 4'h0);
        tick();
        tgt(1'b0, 1'b0, 1'b1);
        #1;
        chk("sw_last", {frame_n, irdy_n, ad_oe, cbe, ad_out},
            {1'b1, 1'b0, 1'b1, 4'h0, 32'hDEADBEEF});
        tick();
        tgt(1'b1, 1'b1, 1'b1);
        #1;
        chk("sw_turn", {frame_n, irdy_n, ad_oe}, {1'b1, 1'b1, 1'b0});
        tick();
        wq.delete();

        // Read burst, len 3, one wait state on beat 2
        exp_rd.push_back(32'h11);
        exp_rd.push_back(32'h22);
        exp_rd.push_back(32'h33);
        exp_st.push_back(2'd0);
        issue(1'b0, 32'h0000_2000, 4'd3, 4'h3);
        tick();
        tgt(1'b0, 1'b0, 1'b1);
        ad_in = 32'h11;
        #1;
        chk("rb_d1", {frame_n, irdy_n, ad_oe, cbe}, {1'b0, 1'b0, 1'b0, 4'h3});
        tick();
        tgt(1'b0, 1'b1, 1'b1);
        ad_in = 32'hBAD;
        #1;
        chk("rb_wait", {frame_n, irdy_n, ad_oe}, {1'b0, 1'b0, 1'b0});
        tick();
        tgt(1'b0, 1'b0, 1'b1);
        ad_in = 32'h22;
        #1;
        chk("rb_d2", {frame_n, irdy_n, ad_oe}, {1'b0, 1'b0, 1'b0});
        tick();
        ad_in = 32'h33;
        #1;
        chk("rb_last", {frame_n, irdy_n, ad_oe}, {1'b1, 1'b0, 1'b0});
        tick();
        tgt(1'b1, 1'b1, 1'b1);
        ad_in = 32'h0;
        tick();

        // Master abort: DEVSEL# never asserted
        exp_st.push_back(2'd1);
        issue(1'b0, 32'h0000_3000, 4'd2, 4'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            chk("ma_wait", {frame_n, irdy_n}, {1'b0, 1'b0});
        end
        tick();
        #1;
        chk("ma_last", {frame_n, irdy_n}, {1'b1, 1'b0});
        tick();
        #1;
        chk("ma_turn", {frame_n, irdy_n, done}, {1'b1, 1'b1, 1'b1});
        tick();

        // Retry: STOP# without TRDY# on first data cycle
        load_wq(32'hCAFE0001, 32'hCAFE0002);
        exp_st.push_back(2'd2);
        issue(1'b1, 32'h0000_4000, 4'd4, 4'h0);
        tick();
        tgt(1'b0, 1'b1, 1'b0);
        #1;
        chk("rt_d1", {frame_n, irdy_n}, {1'b0, 1'b0});
        tick();
        #1;
        chk("rt_last", {frame_n, irdy_n}, {1'b1, 1'b0});
        tick();
        tgt(1'b1, 1'b1, 1'b1);
        tick();
        wq.delete();

        // Disconnect with data on beat 2
        load_wq(32'hA1A1A1A1, 32'hA2A2A2A2);
        exp_wr.push_back(32'hA1A1A1A1);
        exp_wr.push_back(32'hA2A2A2A2);
        exp_st.push_back(2'd3);
        issue(1'b1, 32'h0000_5000, 4'd4, 4'h0);
        tick();
        tgt(1'b0, 1'b0, 1'b1);
        tick();
        tgt(1'b0, 1'b0, 1'b0);
        tick();
        tgt(1'b0, 1'b1, 1'b0);
        #1;
        chk("dc_last", {frame_n, irdy_n}, {1'b1, 1'b0});
        tick();
        tgt(1'b1, 1'b1, 1'b1);
        tick();
        wq.delete();
        wr_data = 32'h0;

        // Reset in the middle of a burst
        load_wq(32'hB1B1B1B1, 32'h0);
        issue(1'b1, 32'h0000_6000, 4'd4, 4'h0);
        tick();
        #1;
        chk("rs_data", {frame_n, irdy_n}, {1'b0, 1'b0});
        rst_n = 1'b0;
        tick();
        #1;
        chk("rs_bus", {frame_n, irdy_n, ad_oe, done},
            {1'b1, 1'b1, 1'b0, 1'b0});
        rst_n = 1'b1;
        wq.delete();
        wr_data = 32'h0;
        tick();
        #1;
        chk("rs_ready", req_ready, 1'b1);

        // Recovery: write with len 0 behaves as a single beat
        load_wq(32'h5A5A_0F0F, 32'h0);
        exp_wr.push_back(32'h5A5A_0F0F);
        exp_st.push_back(2'd0);
        issue(1'b1, 32'h0000_7000, 4'd0, 4'hA);
        tick();
        tgt(1'b0, 1'b0, 1'b1);
        #1;
        chk("l0_last", {frame_n, irdy_n, cbe}, {1'b1, 1'b0, 4'hA});
        tick();
        tgt(1'b1, 1'b1, 1'b1);
        tick();
        tick();
        tick();

        chk("queues_drained",
            64'(exp_addr.size() + exp_wr.size() + exp_rd.size() +
                exp_st.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pci_initiator.md
Name: pci_initiator

Overview:
PCI bus initiator (master) that turns a local request into a PCI memory read or write transaction. It drives FRAME#, IRDY#, C/BE# and AD, and monitors DEVSEL#, TRDY# and STOP#. It is the counterpart of the slave-side command decoder and uses the same command codes: 4'h6 = memory read, 4'h7 = memory write. It sits between local request logic and the shared PCI bus pins.

Parameters:
LEN_W, 4, width of the burst-length field; max burst is 2**LEN_W-1 data phases.
DEVSEL_TIMEOUT, 5, clocks after the address phase to wait for DEVSEL# before a master abort.

Ports:
clk  in  1  bus clock; all logic on posedge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request strobe
req_ready  out  1  high only in IDLE
req_write  in  1  1 = write (cbe 4'h7), 0 = read (cbe 4'h6)
req_addr  in  32  start address
req_len  in  LEN_W  number of data phases; 0 is treated as 1
req_be  in  4  active-low byte enables for all data phases
wr_data  in  32  write data for the current beat
wr_ack  out  1  pulses when a write beat transfers; next word due by the next edge
rd_data  out  32  read data, registered
rd_valid  out  1  1-cycle pulse per read beat transferred
done  out  1  1-cycle pulse at end of transaction
status  out  2  valid with done: 0 OK, 1 MASTER_ABORT, 2 RETRY, 3 DISCONNECT
frame_n  out  1  FRAME#
irdy_n  out  1  IRDY#
cbe  out  4  C/BE#
ad_out  out  32  AD drive value
ad_oe  out  1  AD output enable
ad_in  in  32  AD sampled value
devsel_n  in  1  DEVSEL#
trdy_n  in  1  TRDY#
stop_n  in  1  STOP#

Behaviour:
- Reset (sync, rst_n=0 at posedge), taking effect on that edge even mid-transaction:
  - Bus signals: frame_n=1, irdy_n=1, ad_oe=0, cbe=0, ad_out=0.
  - Local signals: done=0, status=0, rd_valid=0, wr_ack=0, rd_data=0.
  - State returns to IDLE. No protocol cleanup is performed.
- States: IDLE, ADDR, DATA, LAST, TURN.
- IDLE:
  - req_ready=1.
  - req_valid=1 latches addr, len, be and write; next state ADDR.
- ADDR (1 cycle):
  - frame_n=0, irdy_n=1, ad_oe=1, ad_out=addr, cbe=command.
  - Loads the beat counter with len and clears the devsel timer.
  - Next state: DATA if len>1, else LAST.
- DATA:
  - frame_n=0, irdy_n=0, cbe=be.
  - Write: ad_oe=1, ad_out=wr_data. Read: ad_oe=0.
  - The timer counts while devsel_n=1.
- LAST: same as DATA but frame_n=1 (final data phase).
- Transfer occurs at a posedge with irdy_n=0, trdy_n=0, devsel_n=0:
  - Beat counter decrements.
  - Write: wr_ack pulses.
  - Read: rd_data<=ad_in and rd_valid pulses the next cycle.
  - In DATA, when the counter reaches 1 remaining, next state is LAST.
  - In LAST, a transfer moves to TURN with status OK.
- STOP#: stop_n=0 with devsel_n=0 in DATA or LAST.
  - Any coincident transfer counts.
  - From DATA, go to LAST (frame_n drops while irdy_n stays low).
  - In LAST, on trdy_n=0 or stop_n=0, go to TURN.
  - Status is RETRY if zero beats transferred, else DISCONNECT.
- Master abort: timer reaches DEVSEL_TIMEOUT with devsel_n still 1.
  - Go to LAST for exactly one cycle, then TURN with status MASTER_ABORT.
  - No wr_ack or rd_valid is produced.
- TURN (1 cycle):
  - frame_n=1, irdy_n=1, ad_oe=0.
  - done=1 with status; next state IDLE.
  - req_valid is ignored until IDLE (no back-to-back in TURN).
- FRAME# never deasserts without IRDY# asserted. IRDY# never deasserts before its data phase completes, except on abort.
- req_valid outside IDLE is ignored; fields are not re-sampled.

Optional Feature:
- PCI_INITIATOR_PARITY_EN defined:
  - Adds outputs par and par_oe.
  - par = XOR of ad_out and cbe from the previous cycle; par_oe = previous-cycle ad_oe.
  - Both are registered; reset 0.
- Undefined: ports absent; no parity logic.

Decomposition:
- Shared package pci_pkg:
  - command codes CMD_MEM_READ=4'h6 and CMD_MEM_WRITE=4'h7;
  - state enum;
  - status codes ST_OK, ST_MABORT, ST_RETRY, ST_DISC.
- One sub-module pci_devsel_timer: a counter with clear/enable and a timeout flag, parameterised by DEVSEL_TIMEOUT.

Test Plan:
- Single write:
  - stimulus: addr 0x1000, len 1, be 0, data 0xDEADBEEF; target devsel_n=0 and trdy_n=0 on the 1st data cycle;
  - response: ADDR cycle with cbe=7, ad=0x1000; one LAST cycle with frame_n=1, irdy_n=0, ad=0xDEADBEEF; wr_ack once; done with status 0.
- Read burst:
  - stimulus: len 3; trdy_n high for one wait state on beat 2; ad_in supplies 0x11, 0x22, 0x33;
  - response: cbe=6 in ADDR; ad_oe=0 in data phases; 3 rd_valid pulses carrying 0x11, 0x22, 0x33; frame_n high only in the final phase; done status 0.
- Master abort:
  - stimulus: devsel_n held high;
  - response: after 5 clocks, 1 LAST cycle, then done with status 1; no rd_valid.
- Retry:
  - stimulus: stop_n=0, trdy_n=1 on the first data cycle of len 4;
  - response: LAST then TURN; status 2; zero wr_ack.
- Disconnect:
  - stimulus: stop_n=0 with trdy_n=0 on beat 2 of len 4;
  - response: 2 wr_acks; status 3.
- Reset mid-burst:
  - stimulus: rst_n=0 in DATA;
  - response: next edge frame_n=1, irdy_n=1, ad_oe=0, req_ready=1 after release; no done.
